pack_fifo_16i_32o_prefetch: RTL
===============================

Name: pack_fifo_16i_32o_prefetch

Overview:
Single-clock narrow-to-wide prefetch buffer. It accepts 16-bit half-words, pairs them into 32-bit words with the low half first, and queues the words in a register-array FIFO. The read side is first-word-fall-through with a valid/enable handshake. It is the upstream counterpart of the 32-in/16-out asynchronous prefetch FIFO: it rebuilds 32-bit words from the 16-bit stream.

Parameters:
DEPTH_WIDTH, 4, log2 of the FIFO depth in 32-bit words (legal range 2..8; default gives 16 entries).
LOW_FIRST, 1, 1 = first accepted half-word goes to rd_data[15:0]; 0 = first half-word goes to rd_data[31:16].

Ports:
clk  input  1  single clock for all logic.
rst_n  input  1  asynchronous active-low reset.
wr_en  input  1  write request; a half-word is accepted when wr_en and wr_vld are both 1.
wr_vld  output  1  block can accept a half-word this cycle.
wr_data  input  16  half-word to write.
flush  input  1  level request to pad and push a pending half-word.
rd_en  input  1  read pop; a word is consumed when rd_en and rd_vld are both 1.
rd_vld  output  1  rd_data holds a valid word.
rd_data  output  32  head word of the FIFO (prefetched).
half_pend  output  1  pack register holds an unpaired half-word.
level  output  DEPTH_WIDTH+1  number of complete 32-bit words stored.

Behaviour:
- Reset (asynchronous assert on rst_n=0, release on rising clk): pointers=0, level=0, half_pend=0, pack register=0, rd_vld=0, rd_data=0, wr_vld=1. Memory contents are not reset.
- Accept signals:
  - wr_acc = wr_en & wr_vld.
  - rd_acc = rd_en & rd_vld.
  - rd_en while rd_vld=0 is ignored; no underflow occurs.
- wr_vld is combinational from registered state: wr_vld = ~half_pend | (level < 2^DEPTH_WIDTH). Space freed by rd_acc in the same cycle is not counted.
- Packing, with half_pend=0:
  - wr_acc stores wr_data in the pack register and sets half_pend.
  - No FIFO push occurs.
- Packing, with half_pend=1:
  - wr_acc pushes the word {wr_data, pack} (LOW_FIRST=1) or {pack, wr_data} (LOW_FIRST=0).
  - half_pend clears.
- Flush (level sensitive; evaluated only when space exists, i.e. level < depth):
  - flush=1, half_pend=1, no wr_acc: pushes the pending half with the other half zero, e.g. {16'h0000, pack}; half_pend clears.
  - flush=1, half_pend=1, wr_acc: a normal pair completes; flush has no extra effect.
  - flush=1, half_pend=0, wr_acc: pushes the padded {16'h0000, wr_data}; half_pend stays 0.
  - flush=1, half_pend=0, no wr_acc: no action.
  - FIFO full: flush waits and holds no state; it takes effect on the first cycle with space.
- FIFO push and pop:
  - At most one word is pushed per cycle.
  - A push writes mem[wr_ptr]; wr_ptr increments modulo 2^DEPTH_WIDTH.
  - A pop increments rd_ptr modulo 2^DEPTH_WIDTH.
  - Simultaneous push and pop leaves level unchanged; this is legal when full and when level=1.
- Read side (FWFT):
  - rd_vld = (level != 0); rd_data = mem[rd_ptr].
  - Both reflect registered state, so a word pushed at edge N is visible with rd_vld=1 after edge N (latency 1 cycle from the completing wr_acc).
  - rd_data is held stable while rd_vld=1 and rd_en=0.
- Overflow and underflow: impossible by construction. A write with wr_vld=0 is ignored, and the pack register is unchanged.
- Reset mid-operation: all queued words and any pending half are discarded; outputs return to reset values immediately.

Test Plan:
1. Reset, then write 16'h1111, 16'h2222 with rd_en=0 -> after the 2nd write edge: rd_vld=1, rd_data=32'h2222_1111, level=1, half_pend=0.
2. Write 33 half-words 16'h0000..16'h0020 with rd_en=0 (DEPTH_WIDTH=4) -> level=16, half_pend=1, wr_vld=0; a 34th write is ignored. Then read 16 words, expecting 32'h0001_0000, 32'h0003_0002, ..., 32'h001F_001E, with rd_vld falling after the last read.
3. Write 16'hABCD, then hold flush=1 -> next edge pushes 32'h0000_ABCD, half_pend=0, level=1. Then flush=1 together with a write of 16'h5555 -> pushes 32'h0000_5555.
4. Full FIFO with half_pend=1 and flush=1; pop one word -> the padded word is pushed on the following edge, and level returns to 16.
5. Continuous writes with rd_en=1 every cycle -> one word every 2 cycles; level oscillates between 0 and 1; no data loss and word order is preserved. With LOW_FIRST=0, inputs 16'hAAAA, 16'hBBBB produce 32'hAAAA_BBBB.
6. Assert rst_n=0 asynchronously with level=5 and half_pend=1 -> rd_vld, level, and half_pend are 0 before the next clk edge; after release, the first new pair is read back correctly.

Source files
------------

// File: rtl/pack_fifo_16i_32o_prefetch.sv
// Narrow-to-wide prefetch buffer: pairs 16-bit half-words into 32-bit words and
// queues them in a first-word-fall-through register FIFO with an optional pad-and-push flush.
module pack_fifo_16i_32o_prefetch #(
  parameter int DEPTH_WIDTH = 4,
  parameter bit LOW_FIRST   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  output logic                   wr_vld,
  input  logic [15:0]            wr_data,
  input  logic                   flush,
  input  logic                   rd_en,
  output logic                   rd_vld,
  output logic [31:0]            rd_data,
  output logic                   half_pend,
  output logic [DEPTH_WIDTH:0]   level
);

  localparam int unsigned              DEPTH      = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]     FULL_LEVEL = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]     LVL_ONE    = (DEPTH_WIDTH + 1)'(1);
  localparam logic [DEPTH_WIDTH-1:0]   PTR_ONE    = DEPTH_WIDTH'(1);

  logic [31:0]            mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_WIDTH:0]   level_q, level_d;
  logic [15:0]            pack_q, pack_d;
  logic                   pend_q, pend_d;
  logic                   full, wr_acc, rd_acc, push;
  logic [31:0]            push_data;

  // Places the earlier half-word on the side selected by LOW_FIRST.
  function automatic logic [31:0] join_halves(input logic [15:0] first, input logic [15:0] second);
    return LOW_FIRST ? {second, first} : {first, second};
  endfunction

  assign full      = (level_q == FULL_LEVEL);
  assign wr_vld    = ~pend_q | ~full;
  assign wr_acc    = wr_en & wr_vld;
  assign rd_vld    = (level_q != '0);
  assign rd_acc    = rd_en & rd_vld;
  assign half_pend = pend_q;
  assign level     = level_q;
  assign rd_data   = rd_vld ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    push      = 1'b0;
    push_data = '0;
    pack_d    = pack_q;
    pend_d    = pend_q;
    if (pend_q) begin
      // wr_acc with a pending half implies the FIFO has room.
      if (wr_acc) begin
        push      = 1'b1;
        push_data = join_halves(pack_q, wr_data);
        pend_d    = 1'b0;
      end else if (flush && !full) begin
        push      = 1'b1;
        push_data = join_halves(pack_q, 16'h0000);
        pend_d    = 1'b0;
      end
    end else if (wr_acc) begin
      if (flush && !full) begin
        push      = 1'b1;
        push_data = join_halves(wr_data, 16'h0000);
      end else begin
        pack_d = wr_data;
        pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, rd_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pack_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      pack_q  <= pack_d;
      pend_q  <= pend_d;
      if (push)   wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; rd_data is masked while rd_vld=0, so stale words never leak.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
